// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter family: boundary-mode
// encodings and a helper that folds the reserved encoding onto WRAP.
package counter_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_WRAP      = 2'd0,
    MODE_SATURATE  = 2'd1,
    MODE_ONESHOT   = 2'd2,
    MODE_RESERVED  = 2'd3
  } mode_e;

  // Reserved encoding behaves exactly like WRAP, so collapse it here once.
  function automatic mode_e decode_mode(input logic [MODE_W-1:0] raw);
    mode_e m;
    case (raw)
      2'd1:    m = MODE_SATURATE;
      2'd2:    m = MODE_ONESHOT;
      default: m = MODE_WRAP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/clock_prescaler.sv
// Clock-enable prescaler: produces a one-cycle hit every prescale+1
// qualified cycles. A clear (load) restarts the division and suppresses hit.
module clock_prescaler #(
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      qualify,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      hit
);

  logic [PRESCALE_WIDTH-1:0] pcnt;

  // A step is due when a qualified cycle finds the divider at its terminal value.
  assign hit = qualify & ~clear & (pcnt == prescale);

  // Divider state: clear wins, terminal value returns to zero, otherwise advance
  // only on qualified cycles so a disabled counter freezes its phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (clear) begin
      pcnt <= '0;
    end else if (hit) begin
      pcnt <= '0;
    end else if (qualify) begin
      pcnt <= pcnt + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Runtime-programmable up/down counter with bounds, WRAP/SATURATE/ONESHOT
// boundary modes, prescaled stepping and a combinational carry for cascading.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH          = 8,
  parameter int               PRESCALE_WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  input  logic                      down,
  input  logic [MODE_W-1:0]         mode,
  input  logic [WIDTH-1:0]          limit_low,
  input  logic [WIDTH-1:0]          limit_high,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      carry_in,
  input  logic                      overflow_clear,
  output logic [WIDTH-1:0]          count,
  output logic                      terminal,
  output logic                      overflow,
  output logic                      carry_out,
  output logic                      running
);

  logic             qualify;
  logic             load_now;
  logic             hit;
  logic             at_bound;
  logic             bound_event;
  mode_e            mode_sel;
  logic [WIDTH-1:0] count_next;
  logic             terminal_next;
  logic             overflow_next;
  logic             running_next;

  // Load only counts while the block is enabled; it then outranks stepping.
  assign load_now = enable & load;
  assign qualify  = enable & carry_in & running;
  assign mode_sel = decode_mode(mode);

  // Bounds are compared literally, so an out-of-range count is already "at bound".
  assign at_bound    = down ? (count <= limit_low) : (count >= limit_high);
  assign bound_event = hit & at_bound;

  // Carry is combinational so a cascaded stage steps on the same edge.
  assign carry_out = bound_event;

  clock_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .qualify (qualify),
    .clear   (load_now),
    .prescale(prescale),
    .hit     (hit)
  );

  // Next-state for count and flags: load, then boundary event, then plain step.
  always_comb begin
    count_next    = count;
    terminal_next = 1'b0;
    running_next  = running;
    overflow_next = overflow & ~overflow_clear;
    if (load_now) begin
      count_next   = load_value;
      running_next = 1'b1;
    end else if (hit) begin
      if (at_bound) begin
        terminal_next = 1'b1;
        overflow_next = 1'b1;
        case (mode_sel)
          MODE_SATURATE: count_next = count;
          MODE_ONESHOT: begin
            count_next   = count;
            running_next = 1'b0;
          end
          default: count_next = down ? limit_high : limit_low;
        endcase
      end else begin
        count_next = down ? (count - WIDTH'(1)) : (count + WIDTH'(1));
      end
    end
  end

  // Registered outputs; reset aborts counting immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= RESET_VALUE;
      terminal <= 1'b0;
      overflow <= 1'b0;
      running  <= 1'b1;
    end else begin
      count    <= count_next;
      terminal <= terminal_next;
      overflow <= overflow_next;
      running  <= running_next;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: directed scenarios with literal expectations,
// a randomized phase checked every cycle against a behavioural model, and a
// two-stage cascade.
module tb_updown_mod_counter;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0, load = 1'b0, down = 1'b0;
  logic          carry_in = 1'b1, overflow_clear = 1'b0;
  logic [W-1:0]  load_value = '0, limit_low = '0, limit_high = '0;
  logic [1:0]    mode = 2'd0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  count;
  logic          terminal, overflow, carry_out, running;

  logic          c_enable = 1'b0, c_load = 1'b0;
  logic [7:0]    c_lv = '0;
  logic [3:0]    lo_count, hi_count;
  logic          lo_term, hi_term, lo_ovf, hi_ovf, lo_carry, hi_carry, lo_run, hi_run;

  int checks = 0;
  int errors = 0;

  int m_count, m_pcnt;
  bit m_term, m_ovf, m_run;

  updown_mod_counter #(.WIDTH(W), .PRESCALE_WIDTH(PW), .RESET_VALUE('0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .down(down), .mode(mode),
    .limit_low(limit_low), .limit_high(limit_high), .prescale(prescale),
    .carry_in(carry_in), .overflow_clear(overflow_clear),
    .count(count), .terminal(terminal), .overflow(overflow),
    .carry_out(carry_out), .running(running)
  );

  updown_mod_counter #(.WIDTH(4), .PRESCALE_WIDTH(PW), .RESET_VALUE('0)) u_lo (
    .clock(clock), .reset(reset), .enable(c_enable), .load(c_load),
    .load_value(c_lv[3:0]), .down(1'b0), .mode(2'd0),
    .limit_low(4'd0), .limit_high(4'd15), .prescale(4'd0),
    .carry_in(1'b1), .overflow_clear(1'b0),
    .count(lo_count), .terminal(lo_term), .overflow(lo_ovf),
    .carry_out(lo_carry), .running(lo_run)
  );

  updown_mod_counter #(.WIDTH(4), .PRESCALE_WIDTH(PW), .RESET_VALUE('0)) u_hi (
    .clock(clock), .reset(reset), .enable(c_enable), .load(c_load),
    .load_value(c_lv[7:4]), .down(1'b0), .mode(2'd0),
    .limit_low(4'd0), .limit_high(4'd15), .prescale(4'd0),
    .carry_in(lo_carry), .overflow_clear(1'b0),
    .count(hi_count), .terminal(hi_term), .overflow(hi_ovf),
    .carry_out(hi_carry), .running(hi_run)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_bound(input int c);
    if (down) return c <= int'(limit_low);
    return c >= int'(limit_high);
  endfunction

  // Behavioural reference: plain integer arithmetic modulo 256 / 16.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_count <= 0; m_pcnt <= 0; m_term <= 1'b0; m_ovf <= 1'b0; m_run <= 1'b1;
    end else begin : mdl
      bit ev;
      ev = 1'b0;
      m_term <= 1'b0;
      if (enable && load) begin
        m_count <= int'(load_value);
        m_pcnt  <= 0;
        m_run   <= 1'b1;
      end else if (enable && carry_in && m_run) begin
        if (m_pcnt == int'(prescale)) begin
          m_pcnt <= 0;
          if (model_bound(m_count)) begin
            ev = 1'b1;
            m_term <= 1'b1;
            m_ovf  <= 1'b1;
            if (mode == 2'd2) m_run <= 1'b0;
            else if (mode != 2'd1) m_count <= down ? int'(limit_high) : int'(limit_low);
          end else begin
            m_count <= (m_count + (down ? 255 : 1)) % 256;
          end
        end else begin
          m_pcnt <= (m_pcnt + 1) % 16;
        end
      end
      if (overflow_clear && !ev) m_ovf <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset) begin : cmp
      bit exp_carry;
      exp_carry = enable && !load && carry_in && m_run &&
                  (m_pcnt == int'(prescale)) && model_bound(m_count);
      check("model_count", 32'(count), 32'(m_count));
      check("model_terminal", 32'(terminal), 32'(m_term));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
      check("model_running", 32'(running), 32'(m_run));
      check("model_carry_out", 32'(carry_out), 32'(exp_carry));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    check("reset_count", 32'(count), 32'h0);
    check("reset_terminal", 32'(terminal), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);
    check("reset_running", 32'(running), 32'h1);
    tick(); tick();
    reset = 1'b1;

    // WRAP up 3..6
    enable = 1'b1; mode = 2'd0; down = 1'b0; limit_low = 8'd3; limit_high = 8'd6;
    prescale = '0; load = 1'b1; load_value = 8'd3;
    tick(); load = 1'b0;
    check("wrap_load", 32'(count), 32'd3);
    tick(); check("wrap_4", 32'(count), 32'd4);
    tick(); tick();
    check("wrap_6", 32'(count), 32'd6);
    check("wrap_6_term", 32'(terminal), 32'd0);
    check("wrap_6_carry", 32'(carry_out), 32'd1);
    tick();
    check("wrap_back", 32'(count), 32'd3);
    check("wrap_term", 32'(terminal), 32'd1);
    check("wrap_ovf", 32'(overflow), 32'd1);
    tick();
    check("wrap_term_once", 32'(terminal), 32'd0);
    check("wrap_ovf_sticky", 32'(overflow), 32'd1);
    overflow_clear = 1'b1;
    tick(); overflow_clear = 1'b0;
    check("wrap_ovf_clear", 32'(overflow), 32'd0);

    // Prescale by 3 with an enable freeze
    prescale = 4'd2; limit_low = 8'd0; limit_high = 8'd255;
    load = 1'b1; load_value = 8'd0;
    tick(); load = 1'b0;
    tick(); tick();
    check("pre_hold", 32'(count), 32'd0);
    tick(); check("pre_step", 32'(count), 32'd1);
    tick(); enable = 1'b0;
    repeat (5) tick();
    check("pre_freeze", 32'(count), 32'd1);
    enable = 1'b1;
    tick(); check("pre_resume1", 32'(count), 32'd1);
    tick(); check("pre_resume2", 32'(count), 32'd2);

    // SATURATE down to 2
    prescale = '0; mode = 2'd1; down = 1'b1; limit_low = 8'd2; limit_high = 8'd200;
    load = 1'b1; load_value = 8'd4; overflow_clear = 1'b1;
    tick(); load = 1'b0; overflow_clear = 1'b0;
    check("sat_load", 32'(count), 32'd4);
    check("sat_ovf0", 32'(overflow), 32'd0);
    tick(); check("sat_3", 32'(count), 32'd3);
    tick(); check("sat_2", 32'(count), 32'd2);
    check("sat_2_term", 32'(terminal), 32'd0);
    tick(); check("sat_hold", 32'(count), 32'd2);
    check("sat_term1", 32'(terminal), 32'd1);
    check("sat_ovf1", 32'(overflow), 32'd1);
    overflow_clear = 1'b1;
    tick(); overflow_clear = 1'b0;
    check("sat_hold2", 32'(count), 32'd2);
    check("sat_term2", 32'(terminal), 32'd1);
    check("sat_set_wins", 32'(overflow), 32'd1);

    // ONESHOT up 0..3
    mode = 2'd2; down = 1'b0; limit_low = 8'd0; limit_high = 8'd3;
    load = 1'b1; load_value = 8'd0;
    tick(); load = 1'b0;
    tick(); tick(); tick();
    check("os_3", 32'(count), 32'd3);
    check("os_run", 32'(running), 32'd1);
    tick();
    check("os_hold", 32'(count), 32'd3);
    check("os_stop", 32'(running), 32'd0);
    check("os_term", 32'(terminal), 32'd1);
    tick();
    check("os_stay", 32'(count), 32'd3);
    check("os_term_off", 32'(terminal), 32'd0);
    load = 1'b1; load_value = 8'd1;
    tick(); load = 1'b0;
    check("os_reload", 32'(count), 32'd1);
    check("os_rerun", 32'(running), 32'd1);
    check("os_reload_term", 32'(terminal), 32'd0);

    // Asynchronous reset mid-count
    mode = 2'd0; limit_low = 8'd0; limit_high = 8'd255;
    load = 1'b1; load_value = 8'h37;
    tick(); load = 1'b0;
    check("rst_pre", 32'(count), 32'h37);
    #2 reset = 1'b0;
    #1;
    check("rst_async_count", 32'(count), 32'h0);
    check("rst_async_ovf", 32'(overflow), 32'h0);
    check("rst_async_run", 32'(running), 32'h1);
    tick(); reset = 1'b1;
    tick(); check("rst_resume", 32'(count), 32'h1);

    // Two-stage cascade
    enable = 1'b0;
    c_enable = 1'b1; c_load = 1'b1; c_lv = 8'h0F;
    tick(); c_load = 1'b0;
    check("casc_load", 32'({hi_count, lo_count}), 32'h0F);
    tick();
    check("casc_carry", 32'({hi_count, lo_count}), 32'h10);
    c_load = 1'b1; c_lv = 8'hFF;
    tick(); c_load = 1'b0;
    tick();
    check("casc_wrap", 32'({hi_count, lo_count}), 32'h00);
    check("casc_hi_term", 32'(hi_term), 32'h1);
    c_enable = 1'b0;

    // Randomized phase against the model
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 499) == 0) reset = 1'b0;
      enable         = ($urandom_range(0, 9) != 0);
      load           = ($urandom_range(0, 19) == 0);
      load_value     = W'($urandom_range(0, 255));
      carry_in       = ($urandom_range(0, 9) != 0);
      overflow_clear = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) down = ~down;
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        int lo;
        lo = $urandom_range(0, 247);
        limit_low  = W'(lo);
        limit_high = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255))
                                                 : W'(lo + $urandom_range(0, 8));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
